// File: rtl/decereal_pkg.sv
// Shared types and constants for the decereal serial receiver.
// The PARITY state is only reachable when DECEREAL_PARITY_EN is defined.
package decereal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam int   DATA_BITS   = 8;

endpackage

// File: rtl/decereal_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module byte_fifo
    import decereal_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 do_push, do_pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout    = empty ? '0 : mem_q[rd_q];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/decereal.sv
// Serial byte receiver with a FWFT output FIFO.
// Define DECEREAL_PARITY_EN to expect an even-parity bit before the stop bit.
module decereal
    import decereal_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 serialIn,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 empty,
    output logic                 full,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic                 rx_prev_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 stop_hit;
    logic                 par_ok;
    logic                 push;
`ifdef DECEREAL_PARITY_EN
    logic                 par_q;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        stop_hit = (state_q == STOP) && (cnt_q == LAST);
`ifdef DECEREAL_PARITY_EN
        par_ok   = ~^{shreg_q, par_q};
`else
        par_ok   = 1'b1;
`endif
        push     = stop_hit && (rx_s == IDLE_LEVEL) && par_ok;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q      <= '1;
            rx_prev_q   <= IDLE_LEVEL;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef DECEREAL_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], serialIn};
            rx_prev_q   <= rx_s;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q == IDLE_LEVEL && rx_s == START_LEVEL)
                        state_q <= START;
                end
                START: begin
                    if (cnt_q == HALF) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= (rx_s == START_LEVEL) ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q          <= '0;
                        shreg_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + 1'b1;
                        if (idx_q == 3'(DATA_BITS - 1))
`ifdef DECEREAL_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                    end
                end
`ifdef DECEREAL_PARITY_EN
                PARITY: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a start edge in its second half is seen.
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                        frame_err_q <= (rx_s != IDLE_LEVEL) || !par_ok;
                        overrun_q   <= push && full && !rd;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (push),
        .din    (shreg_q),
        .pop    (rd),
        .dout   (data),
        .empty  (empty),
        .full   (full)
    );

endmodule

// File: tb/tb_decereal.sv
// Directed self-checking bench for decereal (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Define DECEREAL_PARITY_EN here and in the RTL to exercise the parity build.
module tb_decereal;

    localparam int CPB = 16;
`ifdef DECEREAL_PARITY_EN
    localparam int STOP_K = 171;
`else
    localparam int STOP_K = 155;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic       serialIn;
    logic       rd;
    logic [7:0] data;
    logic       empty, full, busy, frame_err, overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int busy_min, fall_k, ferr_cnt, ferr_k, ovr_cnt;
    int tot, saw;

    decereal #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .serialIn  (serialIn),
        .rd        (rd),
        .data      (data),
        .empty     (empty),
        .full      (full),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drives one frame starting at a negedge; k counts posedges since the start bit.
    task automatic send(input logic [7:0] b, input logic stop_bit,
                        input logic par_bit);
        logic [10:0] bits;
        int nb;
        int k;
`ifdef DECEREAL_PARITY_EN
        bits = {stop_bit, par_bit, b, 1'b0};
        nb   = 11;
`else
        bits = {par_bit, stop_bit, b, 1'b0};
        nb   = 10;
`endif
        k = 0; busy_min = 1; fall_k = 0;
        ferr_cnt = 0; ferr_k = 0; ovr_cnt = 0;
        for (int i = 0; i < nb; i++) begin
            serialIn = bits[i];
            repeat (CPB) begin
                @(negedge sysclk);
                k++;
                if (k >= 3 && k < STOP_K && busy !== 1'b1) busy_min = 0;
                if (empty === 1'b0 && fall_k == 0) fall_k = k;
                if (frame_err === 1'b1) begin ferr_cnt++; ferr_k = k; end
                if (overrun === 1'b1) ovr_cnt++;
            end
        end
        serialIn = 1'b1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 32'(data), 32'(exp));
        rd = 1'b1;
        @(negedge sysclk);
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; serialIn = 1'b1; rd = 1'b0;
        repeat (3) @(negedge sysclk);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge sysclk);

        // Single byte
        send(8'hA5, 1'b1, 1'b0);
        chk("s1_busy", 32'(busy_min), 32'd1);
        chk("s1_fall_k", 32'(fall_k), 32'(STOP_K));
        chk("s1_ferr", 32'(ferr_cnt), 32'd0);
        chk("s1_idle", 32'(busy), 32'd0);
        pop_chk("s1_data", 8'hA5);
        chk("s1_empty", 32'(empty), 32'd1);

        // Back-to-back frames
        tot = 0;
        send(8'h00, 1'b1, 1'b0); tot += ferr_cnt;
        send(8'hFF, 1'b1, 1'b0); tot += ferr_cnt;
        send(8'h3C, 1'b1, 1'b0); tot += ferr_cnt;
        chk("s2_ferr", 32'(tot), 32'd0);
        pop_chk("s2_d0", 8'h00);
        pop_chk("s2_d1", 8'hFF);
        pop_chk("s2_d2", 8'h3C);
        chk("s2_empty", 32'(empty), 32'd1);

        // Overrun on fifth byte
        send(8'h01, 1'b1, 1'b1);
        send(8'h02, 1'b1, 1'b1);
        send(8'h03, 1'b1, 1'b0);
        chk("s3_notfull", 32'(full), 32'd0);
        send(8'h04, 1'b1, 1'b1);
        chk("s3_full", 32'(full), 32'd1);
        send(8'h05, 1'b1, 1'b0);
        chk("s3_ovr", 32'(ovr_cnt), 32'd1);
        chk("s3_full2", 32'(full), 32'd1);
        pop_chk("s3_d1", 8'h01);
        pop_chk("s3_d2", 8'h02);
        pop_chk("s3_d3", 8'h03);
        pop_chk("s3_d4", 8'h04);
        chk("s3_empty", 32'(empty), 32'd1);

        // Bad stop bit, then a short glitch
        send(8'h55, 1'b0, 1'b0);
        chk("s4_ferr", 32'(ferr_cnt), 32'd1);
        chk("s4_ferr_k", 32'(ferr_k), 32'(STOP_K));
        chk("s4_empty", 32'(empty), 32'd1);
        repeat (20) @(negedge sysclk);
        saw = 0; tot = 0;
        serialIn = 1'b0;
        for (int i = 0; i < 44; i++) begin
            if (i == 4) serialIn = 1'b1;
            @(negedge sysclk);
            if (busy === 1'b1) saw = 1;
            if (frame_err === 1'b1) tot++;
        end
        chk("s4_glitch_start", 32'(saw), 32'd1);
        chk("s4_glitch_busy", 32'(busy), 32'd0);
        chk("s4_glitch_empty", 32'(empty), 32'd1);
        chk("s4_glitch_ferr", 32'(tot), 32'd0);

        // Reset in the middle of a frame flushes the FIFO
        send(8'h11, 1'b1, 1'b0);
        chk("s5_pre", 32'(empty), 32'd0);
        serialIn = 1'b0; repeat (CPB) @(negedge sysclk);
        serialIn = 1'b1; repeat (CPB) @(negedge sysclk);
        serialIn = 1'b0; repeat (CPB) @(negedge sysclk);
        serialIn = 1'b0; repeat (CPB) @(negedge sysclk);
        serialIn = 1'b0; repeat (CPB / 2) @(negedge sysclk);
        chk("s5_midbusy", 32'(busy), 32'd1);
        reset = 1'b1; serialIn = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_empty", 32'(empty), 32'd1);
        repeat (40) @(negedge sysclk);
        send(8'h7E, 1'b1, 1'b0);
        chk("s5_ferr", 32'(ferr_cnt), 32'd0);
        pop_chk("s5_data", 8'h7E);
        chk("s5_empty2", 32'(empty), 32'd1);

`ifdef DECEREAL_PARITY_EN
        send(8'h03, 1'b1, 1'b1);
        chk("s6_bad_ferr", 32'(ferr_cnt), 32'd1);
        chk("s6_bad_empty", 32'(empty), 32'd1);
        send(8'h03, 1'b1, 1'b0);
        chk("s6_ok_ferr", 32'(ferr_cnt), 32'd0);
        pop_chk("s6_ok_data", 8'h03);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
